alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU for the multi-cycle RISC-V datapath. Sits directly downstream of the ALU decoder and consumes its 4-bit ALUControl code together with SrcA/SrcB.
- Logical, arithmetic and compare ops complete in one cycle.
- SLL, SRL and SRA use an iterative 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides let the control FSM stall on the result.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; WIDTH must equal 2**SHAMT_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request.
- ALUControl  in  4  op code from the ALU decoder.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B; bits [SHAMT_W-1:0] give the shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- ALUResult  out  WIDTH  result.
- Zero  out  1  ALUResult == 0.
- IllegalOp  out  1  unsupported ALUControl code for this result.

Behaviour:
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
  - 0100 SLL, 0101 SLT (signed), 0110 SLTU, 0111 XOR.
  - 1000 SRL, 1001 SRA.
  - 1010-1111 illegal.
- Arithmetic is modulo 2**WIDTH. SLT/SLTU return 1 or 0 in bit 0, all upper bits 0.
- FSM states are IDLE, SHIFT and DONE.
- Handshakes:
  - in_ready = (state == IDLE); the input is accepted when in_valid & in_ready.
  - out_valid = (state == DONE); the output is taken when out_valid & out_ready.
- IDLE on accept, non-shift op: compute the result, register ALUResult/Zero/IllegalOp, go to DONE. out_valid is high the cycle after accept (latency 1).
- IDLE on accept, shift op:
  - Latch SrcA into the work register and shamt into a down-counter.
  - shamt == 0: go to DONE with result = SrcA (latency 1).
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - Shift the work register 1 bit: SLL inserts 0 at the LSB; SRL inserts 0 at the MSB; SRA replicates the MSB.
  - Decrement the counter. When the counter reaches 0, go to DONE.
  - Latency for shamt k > 0: out_valid is high k+1 cycles after accept. Shamt 31 gives latency 32.
- Illegal op: ALUResult = 0, Zero = 1, IllegalOp = 1, latency 1. IllegalOp is 0 for all legal ops.
- DONE: ALUResult, Zero and IllegalOp are held stable while out_ready is low, for any number of cycles. On the handshake, go to IDLE; in_ready rises the next cycle.
- No overlap: a new request cannot be accepted in the same cycle as a result handshake.
- Inputs are sampled only on the accept cycle. Changes to SrcA/SrcB/ALUControl during SHIFT or DONE have no effect.
- Reset (reset = 0, any time, including mid-SHIFT or in DONE):
  - Immediately forces state to IDLE and clears ALUResult, counter and work register to 0.
  - Outputs under reset: Zero = 1, IllegalOp = 0, out_valid = 0, in_ready = 1.
  - An in-flight operation is discarded with no result produced.
- Zero is always derived from the registered ALUResult.

Test Plan:
- ADD: SrcA=5, SrcB=7 -> ALUResult=12, Zero=0, out_valid 1 cycle after accept.
- SUB and compares:
  - SUB 3-3 -> ALUResult=0, Zero=1.
  - SLT -1 vs 1 -> ALUResult=1.
  - SLTU 0xFFFFFFFF vs 1 -> ALUResult=0.
- SRA 0x80000000 by 4 -> 0xF8000000, out_valid exactly 5 cycles after accept. SRL of the same operands -> 0x08000000.
- SLL shamt 0, SrcA=0xDEADBEEF -> 0xDEADBEEF at latency 1. SLL 1 by 31 -> 0x80000000 at latency 32.
- Backpressure: hold out_ready=0 for 3 cycles on an XOR 0xF0F0 ^ 0x0FF0 -> ALUResult=0xFF00 stable and in_ready=0 throughout. Handshake on cycle 4, then in_ready=1 the next cycle.
- Reset mid-SHIFT: assert reset during an SLL by 20 at cycle 5 -> out_valid=0, in_ready=1, ALUResult=0 immediately. After release, a new ADD 1+1 returns 2.
- Illegal code 4'b1011 -> ALUResult=0, IllegalOp=1, latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU for the multi-cycle RISC-V datapath. Logical, arithmetic
// and compare operations complete one cycle after accept. SLL/SRL/SRA run on
// an iterative shifter that moves the operand one bit per cycle, so a shift
// by k (k > 0) takes k+1 cycles from accept to result.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    request valid           in_ready   unit idle, can accept
//   ALUControl  4-bit op code           SrcA/SrcB  operands (SrcB low bits = shamt)
//   out_valid   result valid            out_ready  consumer takes the result
//   ALUResult   registered result       Zero       ALUResult == 0
//   IllegalOp   result came from an unsupported op code
//
// WIDTH must equal 2**SHAMT_W.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             IllegalOp
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   result_reg,  result_next;
    logic [WIDTH-1:0]   work_reg,    work_next;
    logic [SHAMT_W-1:0] cnt_reg,     cnt_next;
    logic               illegal_reg, illegal_next;
    logic               shl_reg,     shl_next;   // 1: shift left, 0: shift right
    logic               sra_reg,     sra_next;   // right shift fills with MSB

    logic [WIDTH-1:0]   alu_value;
    logic [WIDTH-1:0]   shl_value;
    logic [WIDTH-1:0]   shr_value;
    logic [WIDTH-1:0]   shift_step;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               is_illegal;

    assign shamt      = SrcB[SHAMT_W-1:0];
    assign is_shift   = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                        (ALUControl == OP_SRA);
    assign is_illegal = (ALUControl > OP_SRA);

    // Single-cycle operations
    always_comb begin
        alu_value = '0;
        case (ALUControl)
            OP_ADD:  alu_value = SrcA + SrcB;
            OP_SUB:  alu_value = SrcA - SrcB;
            OP_AND:  alu_value = SrcA & SrcB;
            OP_OR:   alu_value = SrcA | SrcB;
            OP_XOR:  alu_value = SrcA ^ SrcB;
            OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: alu_value = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            default: alu_value = '0;
        endcase
    end

    // One-bit shift of the work register, built per bit position
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift_bit
            if (gi == 0) begin : g_shl_lsb
                assign shl_value[gi] = 1'b0;
            end else begin : g_shl_mid
                assign shl_value[gi] = work_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_shr_msb
                assign shr_value[gi] = sra_reg & work_reg[WIDTH-1];
            end else begin : g_shr_mid
                assign shr_value[gi] = work_reg[gi+1];
            end
        end
    endgenerate

    assign shift_step = shl_reg ? shl_value : shr_value;

    // Next-state and datapath control
    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        work_next    = work_reg;
        cnt_next     = cnt_reg;
        illegal_next = illegal_reg;
        shl_next     = shl_reg;
        sra_next     = sra_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = DONE;
                    if (is_shift) begin
                        work_next    = SrcA;
                        cnt_next     = shamt;
                        shl_next     = (ALUControl == OP_SLL);
                        sra_next     = (ALUControl == OP_SRA);
                        illegal_next = 1'b0;
                        if (shamt == '0) begin
                            result_next = SrcA;
                        end else begin
                            state_next = SHIFT;
                        end
                    end else begin
                        result_next  = is_illegal ? '0 : alu_value;
                        illegal_next = is_illegal;
                    end
                end
            end
            SHIFT: begin
                work_next = shift_step;
                cnt_next  = cnt_reg - CNT_ONE;
                // Last step: publish the shifted value directly
                if (cnt_reg == CNT_ONE) begin
                    result_next = shift_step;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            work_reg    <= '0;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            shl_reg     <= 1'b0;
            sra_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            work_reg    <= work_next;
            cnt_reg     <= cnt_next;
            illegal_reg <= illegal_next;
            shl_reg     <= shl_next;
            sra_reg     <= sra_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign ALUResult = result_reg;
    assign Zero      = (result_reg == '0);
    assign IllegalOp = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Drives directed and random requests into alu_exec_unit. A compare process
// on the falling clock edge checks every cycle against a behavioural model
// of the op set (result, Zero, IllegalOp, latency, handshake levels); the
// directed requests additionally pin hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        IllegalOp;

    int tests = 0;
    int fails = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .IllegalOp  (IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Behavioural model of one request: result, illegal flag, latency.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: begin r = a << sh;           lat = (sh == 0) ? 1 : sh + 1; end
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a ^ b;
            4'd8: begin r = a >> sh;           lat = (sh == 0) ? 1 : sh + 1; end
            4'd9: begin r = $signed(a) >>> sh; lat = (sh == 0) ? 1 : sh + 1; end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // Compare process: runs on every falling edge
    bit          mon_pending = 0;
    bit          mon_seen    = 0;
    int          mon_cyc     = 0;
    logic [31:0] exp_res;
    logic        exp_ill;
    int          exp_lat;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset out_valid", out_valid, 0);
                check("reset in_ready",  in_ready,  1);
                check("reset ALUResult", ALUResult, 0);
                check("reset Zero",      Zero,      1);
                check("reset IllegalOp", IllegalOp, 0);
                mon_pending = 0;
            end else begin
                if (mon_pending) begin
                    mon_cyc++;
                    if (out_valid) begin
                        if (!mon_seen) begin
                            check("latency", mon_cyc, exp_lat);
                            mon_seen = 1;
                        end
                        check("ALUResult",        ALUResult, exp_res);
                        check("Zero",             Zero,      (exp_res == 32'd0));
                        check("IllegalOp",        IllegalOp, exp_ill);
                        check("in_ready in DONE", in_ready,  0);
                        if (out_ready) mon_pending = 0;
                    end else if (mon_seen) begin
                        check("out_valid held until handshake", out_valid, 1);
                        mon_pending = 0;
                    end else begin
                        check("in_ready while busy", in_ready, 0);
                        if (mon_cyc >= exp_lat) begin
                            check("out_valid at expected latency", out_valid, 1);
                            mon_pending = 0;
                        end
                    end
                end else begin
                    check("idle out_valid", out_valid, 0);
                    check("idle in_ready",  in_ready,  1);
                end
                if (in_valid && in_ready) begin
                    model(ALUControl, SrcA, SrcB, exp_res, exp_ill, exp_lat);
                    mon_pending = 1;
                    mon_seen    = 0;
                    mon_cyc     = 0;
                end
            end
        end
    end

    // One request: called at posedge+1 with the unit idle. Inputs are
    // scrambled after accept; the result is held for 'hold' cycles.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit lit, input logic [31:0] lit_res,
                         input logic lit_ill, input int lit_lat);
        int lat;
        check("in_ready before issue", in_ready, 1);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ALUControl = 4'($urandom_range(0, 15));
        SrcA       = $urandom;
        SrcB       = $urandom;
        lat = 1;
        while (!out_valid) begin
            if (lat >= 40) begin
                check("wait for out_valid", out_valid, 1);
                finish_run();
            end
            @(posedge clk); #1;
            lat++;
        end
        $display("[TB] op=%b a=%08h b=%08h -> res=%08h ill=%0b lat=%0d hold=%0d",
                 op, a, b, ALUResult, IllegalOp, lat, hold);
        if (lit) begin
            check("literal ALUResult", ALUResult, lit_res);
            check("literal Zero",      Zero,      (lit_res == 32'd0));
            check("literal IllegalOp", IllegalOp, lit_ill);
            check("literal latency",   lat,       lit_lat);
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ALUControl = 4'd0;
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Directed requests with literal expectations
        issue(4'b0000, 32'd5,        32'd7,  0, 1, 32'd12,        1'b0, 1);
        issue(4'b0001, 32'd3,        32'd3,  0, 1, 32'd0,         1'b0, 1);
        issue(4'b0101, 32'hFFFFFFFF, 32'd1,  0, 1, 32'd1,         1'b0, 1);
        issue(4'b0110, 32'hFFFFFFFF, 32'd1,  0, 1, 32'd0,         1'b0, 1);
        issue(4'b1001, 32'h80000000, 32'd4,  1, 1, 32'hF8000000,  1'b0, 5);
        issue(4'b1000, 32'h80000000, 32'd4,  0, 1, 32'h08000000,  1'b0, 5);
        issue(4'b0100, 32'hDEADBEEF, 32'd0,  0, 1, 32'hDEADBEEF,  1'b0, 1);
        issue(4'b0100, 32'd1,        32'd31, 0, 1, 32'h80000000,  1'b0, 32);
        issue(4'b0111, 32'h0000F0F0, 32'h00000FF0, 3, 1, 32'h0000FF00, 1'b0, 1);
        issue(4'b1011, 32'h12345678, 32'h9ABCDEF0, 0, 1, 32'd0,   1'b1, 1);

        // Reset in the middle of a long shift
        in_valid   = 1'b1;
        ALUControl = 4'b0100;
        SrcA       = 32'h00000003;
        SrcB       = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check("mid-shift reset out_valid", out_valid, 0);
        check("mid-shift reset in_ready",  in_ready,  1);
        check("mid-shift reset ALUResult", ALUResult, 0);
        check("mid-shift reset Zero",      Zero,      1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        issue(4'b0000, 32'd1, 32'd1, 0, 1, 32'd2, 1'b0, 1);

        // Random requests against the model
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            issue(op, a, b, $urandom_range(0, 3), 0, 32'd0, 1'b0, 0);
        end

        repeat (2) begin
            @(posedge clk); #1;
        end
        finish_run();
    end

endmodule
